abc: RTL and testbench
======================

ABC -- requirements
Module: abc

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clock and reset_.
REQ-002 clock  input  1  rising-edge system clock; one serial bit time equals one clock period.
REQ-003 reset_  input  1  asynchronous active-low reset.
REQ-004 colore  input  1  pixel colour: 0 = white, 1 = black; sampled at handshake.
REQ-005 endline  input  1  1 = end-of-line marker; sampled at handshake; colore is ignored when endline = 1.
REQ-006 dav_  input  1  active-low data-valid from the producer.
REQ-007 rfd  output  1  ready-for-data to the producer; 1 = ready.
REQ-008 txd  output  1  serial line, 8N1, LSB first; idle (marking) = 1.

Function
REQ-009 Handshake: with rfd = 1, the block SHALL sample colore/endline at the first rising edge where dav_ = 0, then drive rfd = 0.
REQ-010 rfd SHALL return to 1 only when dav_ = 1 is sampled and no serial frame is pending or in progress.
REQ-011 Run state: 7-bit count and 1-bit run colour; count = 0 means no open run.
REQ-012 Pixel, count = 0: open a run with count = 1, run colour = colore; no byte is sent.
REQ-013 Pixel, same colour, count < 127: increment count; no byte is sent.
REQ-014 Pixel, colour differs from the run colour: send byte {count[6:0], run colour} (colour in bit 0, count in bits 7:1), then open a new run of 1 with the new colour.
REQ-015 Pixel, same colour, count = 127: send {127, colour}, then open a new run of 1 with the same colour.
REQ-016 Endline: send byte 0x00, discard the open run, and set count = 0; this also applies when count = 0.
REQ-017 Frame format: start bit 0 for 1 clock, data bits 0..7 for 1 clock each, stop bit 1 for 1 clock, then txd stays 1; frame length is 10 clocks.
REQ-018 The frame SHALL start on the clock edge after the handshake sample that triggers it.
REQ-019 At most one frame SHALL be produced per handshake, except under REQ-026.
REQ-020 rfd SHALL stay 0 for the whole frame, even if dav_ has already returned to 1.
REQ-021 FSM states: WAIT_DAV, sample, WAIT_DAV_HIGH, TX_START, TX_DATA (3-bit bit index), TX_STOP.
REQ-022 FSM transitions: WAIT_DAV -> sample on dav_ = 0; sample -> TX_START if a byte is due, else WAIT_DAV_HIGH.
REQ-023 FSM transitions: TX_STOP -> WAIT_DAV_HIGH; WAIT_DAV_HIGH -> WAIT_DAV on dav_ = 1, with rfd = 1 in WAIT_DAV.

Reset
REQ-024 While reset_ = 0, the block SHALL hold rfd = 1, txd = 1, count = 0 and run colour = 0, and the FSM SHALL be in WAIT_DAV.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, forcing txd = 1 with no partial byte resumed.

Configuration
REQ-026 Macro ABC_RUN_FLUSH_EN defined: on endline with count > 0, the block SHALL send {count, run colour}, then 0x00 back-to-back (20 clocks), with rfd low throughout.
REQ-027 Macro ABC_RUN_FLUSH_EN undefined: REQ-016 applies unchanged.

Verification
REQ-028 Reset, then release: rfd = 1 and txd = 1 before any handshake.
REQ-029 31 black pixels then 1 white pixel -> one frame with byte 0x3F (31<<1|1); the white pixel opens a run of 1.
REQ-030 After REQ-029, 31 more white pixels (total run 32) then endline -> one frame with byte 0x00; no run byte is sent (flush macro off).
REQ-031 After endline, 33 white pixels then 1 black pixel -> byte 0x42; the frame shows start 0, bits LSB first, stop 1, with txd = 1 before the frame.
REQ-032 128 black pixels then 1 white pixel -> bytes 0xFF, then 0x03; rfd stays low during each frame.
REQ-033 Assert reset_ during data bit 4 of a frame -> txd = 1 and rfd = 1 immediately; the next pixel opens a fresh run with count = 1.

Source files
------------

// File: rtl/abc.sv
// Run-length pixel encoder with 8N1 serial output and dav_/rfd handshake.
// Optional ABC_RUN_FLUSH_EN: on endline, send the open run before 0x00.
module abc (
    input  logic clock,
    input  logic reset_,
    input  logic colore,
    input  logic endline,
    input  logic dav_,
    output logic rfd,
    output logic txd
);

    typedef enum logic [2:0] {
        S_WAIT_DAV,
        S_SAMPLE,
        S_WAIT_HIGH,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  byte_q, byte_d;
    logic        send_q, send_d;
    logic        pend_q, pend_d;
    logic [6:0]  count_q, count_d;
    logic        col_q, col_d;
    logic        hs;

    assign hs = (state_q == S_WAIT_DAV) && !dav_;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_WAIT_DAV;
            bit_q   <= 3'd0;
            byte_q  <= 8'h00;
            send_q  <= 1'b0;
            pend_q  <= 1'b0;
            count_q <= 7'd0;
            col_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            send_q  <= send_d;
            pend_q  <= pend_d;
            count_q <= count_d;
            col_q   <= col_d;
        end
    end

    // Run bookkeeping happens on the handshake edge; the byte waits in byte_q.
    always_comb begin
        count_d = count_q;
        col_d   = col_q;
        byte_d  = byte_q;
        send_d  = send_q;
        pend_d  = pend_q;
        if (hs) begin
            send_d = 1'b0;
            pend_d = 1'b0;
            if (endline) begin
                count_d = 7'd0;
                send_d  = 1'b1;
                byte_d  = 8'h00;
`ifdef ABC_RUN_FLUSH_EN
                if (count_q != 7'd0) begin
                    byte_d = {count_q, col_q};
                    pend_d = 1'b1;
                end
`endif
            end else if (count_q == 7'd0) begin
                count_d = 7'd1;
                col_d   = colore;
            end else if (colore != col_q || count_q == 7'd127) begin
                byte_d  = {count_q, col_q};
                send_d  = 1'b1;
                count_d = 7'd1;
                col_d   = colore;
            end else begin
                count_d = count_q + 7'd1;
            end
        end else if (state_q == S_TX_STOP && pend_q) begin
            byte_d = 8'h00;
            pend_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = 3'd0;
        unique case (state_q)
            S_WAIT_DAV:  if (!dav_) state_d = S_SAMPLE;
            S_SAMPLE:    state_d = send_q ? S_TX_START : S_WAIT_HIGH;
            S_WAIT_HIGH: if (dav_) state_d = S_WAIT_DAV;
            S_TX_START:  state_d = S_TX_DATA;
            S_TX_DATA: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_TX_STOP;
            end
            S_TX_STOP:   state_d = pend_q ? S_TX_START : S_WAIT_HIGH;
            default:     state_d = S_WAIT_DAV;
        endcase
    end

    always_comb begin
        rfd = 1'b0;
        txd = 1'b1;
        unique case (state_q)
            S_WAIT_DAV: rfd = 1'b1;
            S_TX_START: txd = 1'b0;
            S_TX_DATA:  txd = byte_q[bit_q];
            default:    txd = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_abc.sv
// Randomised scoreboard bench for abc: run-length model feeds expected frames,
// a serial monitor decodes txd and compares byte, start edge, stop bit and rfd.
module tb_abc;

    logic clock = 1'b0;
    logic reset_ = 1'b0;
    logic colore = 1'b0;
    logic endline = 1'b0;
    logic dav_ = 1'b1;
    logic rfd;
    logic txd;

    int total = 0;
    int bad = 0;
    int cyc = 0;

`ifdef ABC_RUN_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t exp_q[$];
    int run_len = 0;
    bit run_col = 1'b0;

    abc dut (
        .clock   (clock),
        .reset_  (reset_),
        .colore  (colore),
        .endline (endline),
        .dav_    (dav_),
        .rfd     (rfd),
        .txd     (txd)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] run_byte(input int len, input bit col);
        return 8'(len * 2 + int'(col));
    endfunction

    function automatic void push(input logic [7:0] b, input int start);
        exp_t e;
        e.b = b;
        e.start = start;
        exp_q.push_back(e);
    endfunction

    // Reference: run-length rules applied to whole pixels.
    function automatic void model(input bit col, input bit eol, input int h);
        if (eol) begin
            if (FLUSH && run_len > 0) begin
                push(run_byte(run_len, run_col), h + 1);
                push(8'h00, h + 11);
            end else begin
                push(8'h00, h + 1);
            end
            run_len = 0;
        end else if (run_len == 0) begin
            run_len = 1;
            run_col = col;
        end else if (col != run_col || run_len == 127) begin
            push(run_byte(run_len, run_col), h + 1);
            run_len = 1;
            run_col = col;
        end else begin
            run_len++;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic send(input bit col, input bit eol, input int hold);
        int w = 0;
        int h;
        while (rfd !== 1'b1 && w < 60) begin
            @(negedge clock);
            w++;
        end
        check("rfd_ready", {31'd0, rfd}, 32'd1);
        colore = col;
        endline = eol;
        dav_ = 1'b0;
        h = cyc + 1;
        model(col, eol, h);
        @(negedge clock);
        repeat (hold) @(negedge clock);
        dav_ = 1'b1;
    endtask

    task automatic run(input bit col, input int n);
        for (int i = 0; i < n; i++) send(col, 1'b0, $urandom_range(0, 1));
    endtask

    // Serial monitor: decodes each frame and checks it against the queue head.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_ && txd === 1'b0) begin
                logic [7:0] b;
                logic       stop;
                bit         ok;
                bit         rfd_low;
                int         start;
                exp_t       e;
                start = cyc;
                ok = 1'b1;
                rfd_low = (rfd === 1'b0);
                b = 8'h00;
                stop = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clock);
                    if (!reset_) begin
                        ok = 1'b0;
                        break;
                    end
                    b[i] = txd;
                    if (rfd !== 1'b0) rfd_low = 1'b0;
                end
                if (ok) begin
                    @(negedge clock);
                    if (!reset_) ok = 1'b0;
                    stop = txd;
                    if (rfd !== 1'b0) rfd_low = 1'b0;
                end
                if (ok) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_byte", {24'd0, b}, {24'd0, e.b});
                        check("frame_start", start, e.start);
                        check("stop_bit", {31'd0, stop}, 32'd1);
                        check("rfd_low_in_frame", {31'd0, rfd_low}, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int w;
        #1;
        check("rst_rfd", {31'd0, rfd}, 32'd1);
        check("rst_txd", {31'd0, txd}, 32'd1);
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_rfd", {31'd0, rfd}, 32'd1);
        check("idle_txd", {31'd0, txd}, 32'd1);

        run(1'b1, 31);
        run(1'b0, 1);
        run(1'b0, 31);
        send(1'b0, 1'b1, 0);
        run(1'b0, 33);
        run(1'b1, 1);
        send(1'b1, 1'b1, 1);
        run(1'b1, 128);
        run(1'b0, 1);
        send(1'b0, 1'b1, 0);

        // Abort a frame during data bit 4 with reset.
        run(1'b1, 3);
        send(1'b0, 1'b0, 0);
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (txd !== 1'b0 && w < 40);
        check("abort_start_seen", {31'd0, txd}, 32'd0);
        repeat (5) @(negedge clock);
        #1 reset_ = 1'b0;
        #1;
        check("abort_txd", {31'd0, txd}, 32'd1);
        check("abort_rfd", {31'd0, rfd}, 32'd1);
        exp_q.delete();
        run_len = 0;
        run_col = 1'b0;
        repeat (3) @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        run(1'b1, 5);
        run(1'b0, 1);

        begin
            bit cur = 1'b0;
            for (int i = 0; i < 400; i++) begin
                bit eol = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 39) == 0) cur = ~cur;
                send(eol ? 1'($urandom_range(0, 1)) : cur, eol,
                     $urandom_range(0, 2));
            end
        end
        send(1'b0, 1'b1, 0);

        w = 0;
        while (exp_q.size() > 0 && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("queue_drained", exp_q.size(), 0);
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
